mult_core_seq: RTL and testbench

Sequential shift-add multiplier core that sits directly downstream of the multiplier IP's AXI4-Lite register file. It consumes two operands latched from the slave registers, computes their full-width product over a fixed number of cycles, and presents the result for read-back through the same register file. It uses a valid/ready handshake on both the operand and result sides.

---
 rtl/mult_core_pkg.sv | 21 ++
 rtl/mult_core_dp.sv | 67 ++++++
 rtl/mult_core_seq.sv | 107 ++++++++++
 tb/tb_mult_core_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mult_core_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
// Signed operation is selected at build time with MULT_SIGNED_EN.
package mult_core_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    // Counter must be able to hold the value W itself.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cnt_w(DATA_WIDTH_DEF);

endpackage

// File: rtl/mult_core_dp.sv
// Multiplier datapath: operand registers, accumulator, add/shift step and final negate.
// With MULT_SIGNED_EN defined, operand magnitudes and the product sign are latched at load.
module mult_core_dp
    import mult_core_pkg::*;
#(
    parameter int W  = DATA_WIDTH_DEF,
    parameter int CW = cnt_w(W)
) (
    input  logic            ACLK,
    input  logic            ARESET,
    input  logic            load,
    input  logic            step,
    input  logic            negate,
    input  logic [W-1:0]    a,
    input  logic [W-1:0]    b,
    input  logic [CW-1:0]   cnt,
    output logic [2*W-1:0]  acc
);

    logic [W-1:0]   mcand;
    logic [W-1:0]   mplier;
    logic [W-1:0]   a_mag;
    logic [W-1:0]   b_mag;
    logic [2*W-1:0] addend;

`ifdef MULT_SIGNED_EN
    logic sign;

    // Most-negative input maps to 2^(W-1), which still fits unsigned in W bits.
    assign a_mag = a[W-1] ? -a : a;
    assign b_mag = b[W-1] ? -b : b;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            sign <= 1'b0;
        else if (load)
            sign <= a[W-1] ^ b[W-1];
    end
`else
    logic sign;

    assign a_mag = a;
    assign b_mag = b;
    assign sign  = 1'b0;
`endif

    assign addend = {{W{1'b0}}, mcand} << cnt;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
        end else if (load) begin
            mcand  <= a_mag;
            mplier <= b_mag;
            acc    <= '0;
        end else if (step) begin
            if (mplier[0])
                acc <= acc + addend;
            mplier <= mplier >> 1;
        end else if (negate && sign) begin
            acc <= -acc;
        end
    end

endmodule

// File: rtl/mult_core_seq.sv
// Sequential shift-add multiplier core: FSM, valid/ready handshakes and iteration counter.
// Define MULT_SIGNED_EN for two's-complement operands (adds a FIX cycle, latency W+1).
module mult_core_seq
    import mult_core_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    input  logic                    start_valid,
    output logic                    start_ready,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [2*DATA_WIDTH-1:0] result,
    output logic                    hi_nonzero,
    output logic                    busy
);

    localparam int CW = cnt_w(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    mult_state_t   state;
    mult_state_t   state_nx;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          step;
    logic          negate;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            cnt <= '0;
        else if (accept)
            cnt <= '0;
        else if (step)
            cnt <= cnt + 1'b1;
    end

    always_comb begin
        state_nx    = state;
        start_ready = 1'b0;
        res_valid   = 1'b0;
        busy        = 1'b1;
        accept      = 1'b0;
        step        = 1'b0;
        negate      = 1'b0;
        case (state)
            IDLE: begin
                start_ready = 1'b1;
                busy        = 1'b0;
                if (start_valid) begin
                    accept   = 1'b1;
                    state_nx = CALC;
                end
            end
            // Fixed W iterations; no early exit on zero operands.
            CALC: begin
                step = 1'b1;
                if (cnt == LAST) begin
`ifdef MULT_SIGNED_EN
                    state_nx = FIX;
`else
                    state_nx = DONE;
`endif
                end
            end
`ifdef MULT_SIGNED_EN
            FIX: begin
                negate   = 1'b1;
                state_nx = DONE;
            end
`endif
            DONE: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    mult_core_dp #(
        .W  (DATA_WIDTH),
        .CW (CW)
    ) u_dp (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .load   (accept),
        .step   (step),
        .negate (negate),
        .a      (op_a),
        .b      (op_b),
        .cnt    (cnt),
        .acc    (result)
    );

    assign hi_nonzero = |result[2*DATA_WIDTH-1:DATA_WIDTH];

endmodule

// File: tb/tb_mult_core_seq.sv
// Self-checking bench for mult_core_seq: cycle-level reference model plus directed literal checks.
// Honours MULT_SIGNED_EN for the expected products and latency.
module tb_mult_core_seq;

`ifdef MULT_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        start_valid;
    logic        start_ready;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] result;
    logic        hi_nonzero;
    logic        busy;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    mult_core_seq dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .op_a        (op_a),
        .op_b        (op_b),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .result      (result),
        .hi_nonzero  (hi_nonzero),
        .busy        (busy)
    );

    always #5 ACLK = ~ACLK;
    always @(posedge ACLK) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
`ifdef MULT_SIGNED_EN
        longint sa;
        longint sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
`else
        return {32'd0, a} * {32'd0, b};
`endif
    endfunction

    // Reference model: accept in idle, fixed latency, hold until res_ready.
    bit          m_idle = 1'b1;
    bit          m_done = 1'b0;
    int          m_rem  = 0;
    logic [63:0] m_res  = '0;
    logic [63:0] m_last = '0;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            m_idle = 1'b1;
            m_done = 1'b0;
            m_rem  = 0;
            m_last = '0;
        end else if (m_idle) begin
            if (start_valid) begin
                m_idle = 1'b0;
                m_rem  = LAT;
                m_res  = ref_mul(op_a, op_b);
            end
        end else if (!m_done) begin
            m_rem--;
            if (m_rem == 0) begin
                m_done = 1'b1;
                m_last = m_res;
            end
        end else if (res_ready) begin
            m_done = 1'b0;
            m_idle = 1'b1;
        end
    end

    always @(negedge ACLK) begin
        chk("mdl start_ready", start_ready, m_idle);
        chk("mdl busy", busy, !m_idle);
        chk("mdl res_valid", res_valid, m_done);
        if (m_idle || m_done) begin
            chk("mdl result", result, m_last);
            chk("mdl hi_nonzero", hi_nonzero, |m_last[63:32]);
        end
    end

    task automatic wait_ready();
        int c = 0;
        while (!start_ready && c < 200) begin
            @(posedge ACLK); #1;
            c++;
        end
        if (c >= 200) chk("wait start_ready timeout", 0, 1);
    endtask

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input logic exp_hi, input string name);
        int c = 0;
        wait_ready();
        op_a = a; op_b = b; start_valid = 1'b1; res_ready = 1'b0;
        @(posedge ACLK); #1;
        start_valid = 1'b0;
        while (!res_valid && c < 200) begin
            @(posedge ACLK); #1;
            c++;
        end
        chk({name, " latency"}, 64'(c), 64'(LAT));
        chk({name, " result"}, result, exp);
        chk({name, " hi_nonzero"}, hi_nonzero, exp_hi);
        res_ready = 1'b1;
        @(posedge ACLK); #1;
        res_ready = 1'b0;
        chk({name, " start_ready after accept"}, start_ready, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int last;
        ARESET = 1'b1; op_a = '0; op_b = '0; start_valid = 1'b0; res_ready = 1'b0;
        #1;
        chk("reset start_ready", start_ready, 1);
        chk("reset res_valid", res_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset result", result, 0);
        chk("reset hi_nonzero", hi_nonzero, 0);
        repeat (2) @(posedge ACLK);
        #2 ARESET = 1'b0;

        chk("model 3x4", ref_mul(32'd3, 32'd4), 64'h0000_0000_0000_000C);
        chk("model 7x9", ref_mul(32'd7, 32'd9), 64'd63);

        do_op(32'd3, 32'd4, 64'h0000_0000_0000_000C, 1'b0, "basic 3x4");
        do_op(32'd0, 32'hDEAD_BEEF, 64'd0, 1'b0, "zero operand");
`ifdef MULT_SIGNED_EN
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, "max x max");
        do_op(32'hFFFF_FFFE, 32'd3, 64'hFFFF_FFFF_FFFF_FFFA, 1'b1, "neg2 x 3");
`else
        do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b1, "max x max");
        do_op(32'hFFFF_FFFE, 32'd3, 64'h0000_0002_FFFF_FFFA, 1'b1, "neg2 x 3");
`endif
        do_op(32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b1, "msb x msb");

        // Back-pressure: result held, new operands ignored while busy.
        wait_ready();
        op_a = 32'h1234_5678; op_b = 32'd9; start_valid = 1'b1; res_ready = 1'b0;
        @(posedge ACLK); #1;
        start_valid = 1'b0;
        c = 0;
        while (!res_valid && c < 200) begin
            @(posedge ACLK); #1;
            c++;
        end
        chk("bp latency", 64'(c), 64'(LAT));
        for (int i = 0; i < 5; i++) begin
            op_a = 32'd7; op_b = 32'd7; start_valid = 1'b1;
            @(posedge ACLK); #1;
            chk("bp result held", result, 64'h0000_0000_A3D7_0A38);
            chk("bp res_valid held", res_valid, 1);
            chk("bp busy held", busy, 1);
            chk("bp start_ready low", start_ready, 0);
        end
        start_valid = 1'b0; res_ready = 1'b1;
        @(posedge ACLK); #1;
        res_ready = 1'b0;
        chk("bp start_ready after release", start_ready, 1);
        chk("bp operands not latched", result, 64'h0000_0000_A3D7_0A38);

        // Asynchronous reset at iteration 10 of CALC.
        op_a = 32'd5; op_b = 32'd6; start_valid = 1'b1;
        @(posedge ACLK); #1;
        start_valid = 1'b0;
        repeat (10) @(posedge ACLK);
        #2 ARESET = 1'b1;
        #1;
        chk("abort start_ready", start_ready, 1);
        chk("abort res_valid", res_valid, 0);
        chk("abort busy", busy, 0);
        chk("abort result", result, 0);
        chk("abort hi_nonzero", hi_nonzero, 0);
        repeat (2) @(posedge ACLK);
        #2 ARESET = 1'b0;
        do_op(32'd7, 32'd9, 64'd63, 1'b0, "post-reset 7x9");

        // Back-to-back random operands with res_ready tied high.
        res_ready = 1'b1; start_valid = 1'b1; last = 0;
        for (int i = 0; i < 100; i++) begin
            wait_ready();
            op_a = $urandom; op_b = $urandom;
            @(posedge ACLK); #1;
            if (i > 0) chk("b2b interval", 64'(cyc - last), 64'(LAT + 2));
            last = cyc;
        end
        start_valid = 1'b0;
        wait_ready();
        res_ready = 1'b0;
        repeat (2) @(posedge ACLK);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
